// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-array write port
//            between NUM_REQ writeback sources, with one registered output stage.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [31:0]                    wr_update,
    output logic [DATA_W-1:0]              wr_data,
    output logic                           wr_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]  r_rr_ptr;
    logic              w_grant;
    logic [PTR_W-1:0]  w_win;
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    logic              w_issue;
    logic [PTR_W-1:0]  w_next_ptr;

    // Scan from the farthest offset down so the offset closest to rr_ptr wins.
    always_comb begin : arbitrate
        int idx;
        w_grant = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_grant = 1'b1;
                w_win   = PTR_W'(idx);
            end
        end
        if (flush || !reset) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // Only the winner's bus is looked at, so X on idle requesters cannot leak.
    assign w_addr     = req_addr[w_win];
    assign w_zero     = (w_addr == ADDR_W'(ZERO_REG));
    assign w_issue    = w_grant && !w_zero;
    assign w_next_ptr = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr  <= '0;
            wr_update <= '0;
            wr_data   <= '0;
            wr_busy   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= w_next_ptr;
            end
            if (w_issue) begin
                wr_update <= 32'd1 << w_addr;
                wr_data   <= req_data[w_win];
                wr_busy   <= 1'b1;
            end else begin
                wr_update <= '0;
                wr_busy   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// Self-checking bench for regfile_write_arbiter: directed scenarios plus
// randomized traffic against a round-robin reference model.
module tb_regfile_write_arbiter;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic [N-1:0]        req_valid;
    logic [N-1:0][4:0]   req_addr;
    logic [N-1:0][63:0]  req_data;
    logic [N-1:0]        req_ready;
    logic [31:0]         wr_update;
    logic [63:0]         wr_data;
    logic                wr_busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr;
    logic [31:0] m_upd;
    logic [63:0] m_data;
    logic [N-1:0] exp_ready;
    logic [N-1:0] obs_ready;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_update(wr_update), .wr_data(wr_data), .wr_busy(wr_busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_upd  = '0;
        m_data = '0;
    endtask

    // Samples req_ready mid-cycle, advances the model at the edge, returns #1 after it.
    task automatic tick();
        int w;
        @(negedge clk);
        obs_ready = req_ready;
        w = (flush || !reset) ? -1 : pick(req_valid, m_ptr);
        exp_ready = (w >= 0) ? N'(1 << w) : '0;
        @(posedge clk);
        if (w >= 0) begin
            m_ptr = (w + 1) % N;
            if (req_addr[w] != 5'd31) begin
                m_upd  = 32'd1 << req_addr[w];
                m_data = req_data[w];
            end else begin
                m_upd = '0;
            end
        end else begin
            m_upd = '0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = 5'(i + 1);
            req_data[i] = 64'h0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i] = 64'hA000 + 64'(i);
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        checks++;
        if (wr_update !== 32'h0 || wr_data !== 64'h0 || wr_busy !== 1'b0) begin
            errors++; $display("FAIL reset_out upd %h data %h busy %b want 0", wr_update, wr_data, wr_busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (obs_ready !== 4'b0001 || obs_ready !== exp_ready) begin
            errors++; $display("FAIL reset_first_grant got %b want 0001", obs_ready);
        end
        checks++;
        if (wr_update !== 32'h2 || wr_data !== 64'hA000) begin
            errors++; $display("FAIL reset_first_write upd %h data %h want 2 / a000", wr_update, wr_data);
        end
    endtask

    task automatic test_single_write();
        idle_inputs();
        req_valid   = 4'b0010;
        req_addr[1] = 5'd5;
        req_data[1] = 64'h1234;
        tick();
        checks++;
        if (obs_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b want 0010", obs_ready); end
        checks++;
        if (wr_update !== 32'h0000_0020 || wr_data !== 64'h1234 || wr_busy !== 1'b1) begin
            errors++; $display("FAIL single_out upd %h data %h busy %b want 20/1234/1", wr_update, wr_data, wr_busy);
        end
        req_valid = '0;
        tick();
        checks++;
        if (wr_update !== 32'h0 || wr_busy !== 1'b0 || wr_data !== 64'h1234) begin
            errors++; $display("FAIL single_after upd %h busy %b data %h want 0/0/1234", wr_update, wr_busy, wr_data);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] seq [4];
        seq = '{32'h2, 32'h4, 32'h8, 32'h10};
        idle_inputs();
        // pointer is at 2 after the single write to req1; steer it back to 0
        req_valid = 4'b1000;
        req_addr[3] = 5'd31;
        tick();
        idle_inputs();
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) req_data[i] = {$urandom, $urandom};
            tick();
            checks++;
            if (obs_ready !== exp_ready || obs_ready !== N'(1 << (c % N))) begin
                errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, obs_ready, N'(1 << (c % N)));
            end
            checks++;
            if (wr_update !== seq[c % N] || wr_busy !== 1'b1 || wr_data !== m_data) begin
                errors++; $display("FAIL rr_write c=%0d upd %h busy %b want %h/1", c, wr_update, wr_busy, seq[c % N]);
            end
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        req_valid   = 4'b0100;
        req_addr[2] = 5'd31;
        req_data[2] = 64'hFFFF;
        tick();
        checks++;
        if (obs_ready !== 4'b0100) begin errors++; $display("FAIL zero_ready got %b want 0100", obs_ready); end
        checks++;
        if (wr_update !== 32'h0 || wr_busy !== 1'b0) begin
            errors++; $display("FAIL zero_out upd %h busy %b want 0/0", wr_update, wr_busy);
        end
        req_valid = '1;
        tick();
        checks++;
        if (obs_ready !== 4'b1000) begin errors++; $display("FAIL zero_ptr got %b want 1000", obs_ready); end
    endtask

    task automatic test_flush_withdraw();
        idle_inputs();
        req_valid   = 4'b0001;
        req_addr[0] = 5'd7;
        req_data[0] = 64'h7777;
        tick();
        checks++;
        if (wr_update !== 32'h80) begin errors++; $display("FAIL flush_stage upd %h want 80", wr_update); end
        flush = 1'b1;
        req_valid = 4'b1001;
        tick();
        checks++;
        if (obs_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b want 0000", obs_ready); end
        checks++;
        if (wr_update !== 32'h0 || wr_busy !== 1'b0) begin
            errors++; $display("FAIL flush_out upd %h busy %b want 0/0", wr_update, wr_busy);
        end
        // req3 was blocked by flush and now withdraws
        flush = 1'b0;
        req_valid = '0;
        tick();
        checks++;
        if (obs_ready !== 4'b0000 || wr_update !== 32'h0) begin
            errors++; $display("FAIL withdraw ready %b upd %h want 0/0", obs_ready, wr_update);
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        req_valid   = 4'b0100;
        req_addr[2] = 5'd7;
        req_data[2] = 64'hBEEF;
        tick();
        checks++;
        if (wr_update !== 32'h80) begin errors++; $display("FAIL areset_stage upd %h want 80", wr_update); end
        req_valid = '1;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (wr_update !== 32'h0 || wr_data !== 64'h0 || wr_busy !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL areset_clear upd %h data %h busy %b ready %b want 0", wr_update, wr_data, wr_busy, req_ready);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
        checks++;
        if (obs_ready !== 4'b0001) begin errors++; $display("FAIL areset_ptr got %b want 0001", obs_ready); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                if (req_valid[i]) begin
                    req_addr[i] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
                    req_data[i] = {$urandom, $urandom};
                end else begin
                    req_addr[i] = 'x;
                    req_data[i] = 'x;
                end
            end
            tick();
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready c=%0d got %b want %b", c, obs_ready, exp_ready);
            end
            checks++;
            if (wr_update !== m_upd || wr_busy !== (m_upd != 0) || (m_upd != 0 && wr_data !== m_data)) begin
                errors++; $display("FAIL rand_out c=%0d upd %h data %h want %h/%h", c, wr_update, wr_data, m_upd, m_data);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_reg();
        test_flush_withdraw();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
